// File: rtl/axi_spy_pkg.sv
// Shared AXI types and round-robin pick helper for the write-arbiter slice.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package axi_spy_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // The helper works on a fixed 4-wide request vector. Callers zero-pad
  // narrower vectors; with the padding bits clear, wrapping at 4 gives the
  // same answer as wrapping at the real master count.
  localparam int RR_MAX   = 4;
  localparam int RR_IDX_W = 2;

  // Index of the first set bit at or after ptr, wrapping; returns ptr when
  // req is empty (callers qualify with |req).
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX-1:0]   req,
                                                  input logic [RR_IDX_W-1:0] ptr);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + k[RR_IDX_W-1:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter: request vector + enable -> registered index/one-hot grant.
// Latency: grant registered one cycle after a qualified request; rr_ptr moves on rel.
// Backpressure: none internally; grant holds until the next enabled pick.
module axi_rr_arbiter
  import axi_spy_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          rel,
  output logic          pick_vld,
  output logic [IW-1:0] grant_idx,
  output logic [N-1:0]  grant_oh
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;

  assign pick_vld = en && (|req);
  assign pick     = IW'(rr_pick(RR_MAX'(req), RR_IDX_W'(rr_ptr)));

  // Capture the winner whenever a pick is allowed and somebody is asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx <= '0;
      grant_oh  <= '0;
    end else if (pick_vld) begin
      grant_idx <= pick;
      grant_oh  <= N'(1) << pick;
    end
  end

  // On release, the master just served drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (rel) begin
      rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one downstream AXI write port between NUM_MASTERS masters; grant locked AW..WLAST.
// Latency: s_awvalid -> m_awvalid 1 cycle; AW/W/B payload muxing is combinational after grant.
// Backpressure: per-master ready mirrors downstream ready for the granted master only; B routed by ID.
module axi_write_arbiter
  import axi_spy_pkg::*;
#(
  parameter  int NUM_MASTERS     = 2,
  parameter  int ID_WIDTH        = 4,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 64,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int MIDX_W          = $clog2(NUM_MASTERS),
  localparam int STRB_W          = DATA_WIDTH / 8,
  localparam int MID_W           = ID_WIDTH + MIDX_W
) (
  input  logic                              clk,
  input  logic                              rst,
  // upstream AW
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_awid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          s_awlen,
  input  logic [NUM_MASTERS*3-1:0]          s_awsize,
  input  logic [NUM_MASTERS*2-1:0]          s_awburst,
  input  logic [NUM_MASTERS-1:0]            s_awvalid,
  output logic [NUM_MASTERS-1:0]            s_awready,
  // upstream W
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0]     s_wstrb,
  input  logic [NUM_MASTERS-1:0]            s_wlast,
  input  logic [NUM_MASTERS-1:0]            s_wvalid,
  output logic [NUM_MASTERS-1:0]            s_wready,
  // upstream B
  output logic [ID_WIDTH-1:0]               s_bid,
  output logic [1:0]                        s_bresp,
  output logic [NUM_MASTERS-1:0]            s_bvalid,
  input  logic [NUM_MASTERS-1:0]            s_bready,
  // downstream AW
  output logic [MID_W-1:0]                  m_awid,
  output logic [ADDR_WIDTH-1:0]             m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  // downstream W
  output logic [DATA_WIDTH-1:0]             m_wdata,
  output logic [STRB_W-1:0]                 m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  // downstream B
  input  logic [MID_W-1:0]                  m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready
);

  localparam int CNT_W = 4;

  arb_state_e             state;
  arb_state_e             state_nxt;
  logic [MIDX_W-1:0]      grant_idx;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_vld;
  logic                   arb_en;
  logic                   burst_done;
  logic                   aw_hs;
  logic                   b_hs;
  logic [MIDX_W-1:0]      b_idx;
  logic                   b_idx_ok;
  logic [31:0]            g;

  assign g = 32'(grant_idx);

  axi_rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .en        (arb_en),
    .rel       (burst_done),
    .pick_vld  (pick_vld),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  // State register; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus AW/W muxing; each channel's payload is driven only in its own state.
  always_comb begin
    state_nxt  = state;
    arb_en     = 1'b0;
    burst_done = 1'b0;
    aw_hs      = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    m_awid     = '0;
    m_awaddr   = '0;
    m_awlen    = '0;
    m_awsize   = '0;
    m_awburst  = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wlast    = 1'b0;
    m_wvalid   = 1'b0;
    case (state)
      ARB_IDLE: begin
        arb_en = 1'b1;
        if (pick_vld) state_nxt = ARB_ADDR;
      end
      ARB_ADDR: begin
        m_awid    = {grant_idx, s_awid[g*ID_WIDTH +: ID_WIDTH]};
        m_awaddr  = s_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        m_awlen   = s_awlen[g*8 +: 8];
        m_awsize  = s_awsize[g*3 +: 3];
        m_awburst = s_awburst[g*2 +: 2];
        m_awvalid = s_awvalid[grant_idx];
        s_awready = grant_oh & {NUM_MASTERS{m_awready}};
        aw_hs     = m_awvalid && m_awready;
        if (aw_hs) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        m_wdata  = s_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb  = s_wstrb[g*STRB_W +: STRB_W];
        m_wlast  = s_wlast[grant_idx];
        m_wvalid = s_wvalid[grant_idx];
        s_wready = grant_oh & {NUM_MASTERS{m_wready}};
        if (m_wvalid && m_wready && m_wlast) begin
          burst_done = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // B demux: the master index rides in the top ID bits, so no lookup is needed.
  assign b_idx    = m_bid[ID_WIDTH +: MIDX_W];
  assign b_idx_ok = (32'(b_idx) < 32'(NUM_MASTERS));
  assign s_bvalid = rst ? '0 : (NUM_MASTERS'(m_bvalid) << b_idx);
  assign m_bready = !rst && b_idx_ok && s_bready[b_idx];
  assign s_bid    = m_bid[ID_WIDTH-1:0];
  assign s_bresp  = m_bresp;
  assign b_hs     = m_bvalid && m_bready;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             aw_inc;
    logic             b_dec;

    assign aw_inc      = aw_hs && (grant_idx == MIDX_W'(i));
    assign b_dec       = b_hs && (b_idx == MIDX_W'(i));
    assign eligible[i] = s_awvalid[i] && (cnt < CNT_W'(MAX_OUTSTANDING));

    // Writes awaiting B; a simultaneous AW and B for this master cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (aw_inc && !b_dec) begin
        cnt <= cnt + 1'b1;
      end else if (b_dec && !aw_inc) begin
        assert (cnt != '0);
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with two masters and an outstanding cap of 2.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: bench plays downstream slave and drives m_awready/m_wready/m_bvalid directly.
module tb_axi_write_arbiter;
  import axi_spy_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_awid;
  logic [63:0]  s_awaddr;
  logic [15:0]  s_awlen;
  logic [5:0]   s_awsize;
  logic [3:0]   s_awburst;
  logic [1:0]   s_awvalid;
  logic [1:0]   s_awready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic [1:0]   s_wlast;
  logic [1:0]   s_wvalid;
  logic [1:0]   s_wready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic [1:0]   s_bvalid;
  logic [1:0]   s_bready;
  logic [4:0]   m_awid;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid;
  logic         m_awready;
  logic [63:0]  m_wdata;
  logic [7:0]   m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready;
  logic [4:0]   m_bid;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  axi_write_arbiter #(
    .NUM_MASTERS     (2),
    .ID_WIDTH        (4),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (64),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awid    (s_awid),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awsize  (s_awsize),
    .s_awburst (s_awburst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .m_awid    (m_awid),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awsize  (m_awsize),
    .m_awburst (m_awburst),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
    s_bready = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
  endtask

  task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    s_awid[m*4 +: 4]     = id;
    s_awaddr[m*32 +: 32] = addr;
    s_awlen[m*8 +: 8]    = len;
    s_awsize[m*3 +: 3]   = 3'd3;
    s_awburst[m*2 +: 2]  = AXI_BURST_INCR;
    s_awvalid[m]         = 1'b1;
  endtask

  task automatic set_w(input int m, input logic [63:0] data, input logic last);
    s_wdata[m*64 +: 64] = data;
    s_wstrb[m*8 +: 8]   = 8'hFF;
    s_wlast[m]          = last;
    s_wvalid[m]         = 1'b1;
  endtask

  // One downstream B; s_bready is high on both masters so routing is visible.
  task automatic send_b(input logic [4:0] bid, input logic [1:0] resp, input logic [1:0] exp_v);
    @(negedge clk);
    m_bvalid = 1'b1; m_bid = bid; m_bresp = resp; s_bready = 2'b11;
    #1;
    chk("b_svalid", s_bvalid, exp_v);
    chk("b_sbid", s_bid, bid[3:0]);
    chk("b_sbresp", s_bresp, resp);
    chk("b_mbready", m_bready, 1);
    @(negedge clk);
    m_bvalid = 1'b0; s_bready = 2'b00;
  endtask

  // Single-beat write from a lone requester with a ready downstream.
  task automatic burst1(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [63:0] data);
    logic [4:0] eid;
    logic       mb;
    mb  = (m == 1);
    eid = {mb, id};
    @(negedge clk);
    set_aw(m, id, addr, 8'd0); set_w(m, data, 1'b1); m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk); #1;
    chk("burst_awid", m_awid, eid);
    chk("burst_awaddr", m_awaddr, addr);
    @(negedge clk);
    s_awvalid[m] = 1'b0;
    #1;
    chk("burst_wdata", m_wdata, data);
    @(negedge clk);
    s_wvalid[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int   beats;
    logic mw;

    // ---------------- reset state ----------------
    rst = 1'b1;
    clear_inputs();
    s_awvalid = 2'b11; s_wvalid = 2'b11; m_bvalid = 1'b1; s_bready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_s_awready", s_awready, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_s_wready", s_wready, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_m_awaddr", m_awaddr, 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;

    // ---------------- 1: single master, len=3 ----------------
    @(negedge clk);
    set_aw(0, 4'h3, 32'h100, 8'd3);
    #1;
    chk("t1_latency_idle", m_awvalid, 0);
    @(negedge clk); #1;
    chk("t1_awvalid", m_awvalid, 1);
    chk("t1_awid", m_awid, 5'h03);
    chk("t1_awaddr", m_awaddr, 32'h100);
    chk("t1_awlen", m_awlen, 8'd3);
    chk("t1_awsize", m_awsize, 3'd3);
    chk("t1_awburst", m_awburst, 2'd1);
    chk("t1_awready_wait", s_awready, 2'b00);
    m_awready = 1'b1;
    #1;
    chk("t1_awready", s_awready, 2'b01);
    @(negedge clk);
    s_awvalid[0] = 1'b0; m_awready = 1'b0; m_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_w(0, 64'hA0 + 64'(k), (k == 3));
      #1;
      chk("t1_wvalid", m_wvalid, 1);
      chk("t1_wdata", m_wdata, 64'hA0 + 64'(k));
      chk("t1_wlast", m_wlast, (k == 3));
      chk("t1_wready", s_wready, 2'b01);
      if (k == 0) chk("t1_wstrb", m_wstrb, 8'hFF);
      @(negedge clk);
    end
    s_wvalid[0] = 1'b0;
    #1;
    chk("t1_idle_wvalid", m_wvalid, 0);
    chk("t1_idle_wdata", m_wdata, 0);
    m_bvalid = 1'b1; m_bid = 5'h13; s_bready = 2'b01;
    #1;
    chk("t1_b_route_m1", s_bvalid, 2'b10);
    chk("t1_b_m1_notready", m_bready, 0);
    m_bvalid = 1'b0;
    send_b(5'h03, AXI_RESP_OKAY, 2'b01);

    // ---------------- 2: contention and round robin ----------------
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    set_aw(0, 4'h1, 32'h200, 8'd0); set_w(0, 64'h1111, 1'b1);
    set_aw(1, 4'h2, 32'h300, 8'd0); set_w(1, 64'h2222, 1'b1);
    m_awready = 1'b1; m_wready = 1'b1;
    #1;
    chk("t2_latency_idle", m_awvalid, 0);
    @(negedge clk); #1;
    chk("t2_first_m0", m_awid, 5'h01);
    chk("t2_first_addr", m_awaddr, 32'h200);
    chk("t2_first_awready", s_awready, 2'b01);
    chk("t2_w_blocked_addr", s_wready, 2'b00);
    @(negedge clk);
    s_awvalid[0] = 1'b0;
    #1;
    chk("t2_m0_wdata", m_wdata, 64'h1111);
    chk("t2_m0_wready", s_wready, 2'b01);
    @(negedge clk);
    s_wvalid[0] = 1'b0;
    set_aw(0, 4'h4, 32'h240, 8'd0); set_w(0, 64'h1112, 1'b1);
    #1;
    chk("t2_idle_gap", m_awvalid, 0);
    @(negedge clk); #1;
    chk("t2_second_m1", m_awid, 5'h12);
    chk("t2_second_addr", m_awaddr, 32'h300);
    chk("t2_second_awready", s_awready, 2'b10);
    @(negedge clk);
    s_awvalid[1] = 1'b0;
    #1;
    chk("t2_m1_wdata", m_wdata, 64'h2222);
    chk("t2_m1_wready", s_wready, 2'b10);
    @(negedge clk);
    s_wvalid[1] = 1'b0;
    set_aw(1, 4'h5, 32'h340, 8'd0); set_w(1, 64'h2223, 1'b1);
    @(negedge clk); #1;
    chk("t2_wrap_m0", m_awid, 5'h04);
    chk("t2_wrap_addr", m_awaddr, 32'h240);
    @(negedge clk);
    s_awvalid[0] = 1'b0;
    #1;
    chk("t2_m0b_wdata", m_wdata, 64'h1112);
    @(negedge clk);
    s_wvalid[0] = 1'b0;
    @(negedge clk); #1;
    chk("t2_then_m1", m_awid, 5'h15);
    @(negedge clk);
    s_awvalid[1] = 1'b0;
    #1;
    chk("t2_m1b_wdata", m_wdata, 64'h2223);
    @(negedge clk);
    s_wvalid[1] = 1'b0;
    send_b(5'h01, AXI_RESP_OKAY,   2'b01);
    send_b(5'h12, AXI_RESP_SLVERR, 2'b10);
    send_b(5'h04, AXI_RESP_OKAY,   2'b01);
    send_b(5'h15, AXI_RESP_DECERR, 2'b10);

    // ---------------- 3: outstanding cap ----------------
    burst1(0, 4'h1, 32'h100, 64'h31);
    burst1(0, 4'h2, 32'h200, 64'h32);
    @(negedge clk);
    set_aw(0, 4'h7, 32'h700, 8'd0); set_w(0, 64'h37, 1'b1);
    #1;
    chk("t3_m0_capped_a", m_awvalid, 0);
    @(negedge clk); #1;
    chk("t3_m0_capped_b", m_awvalid, 0);
    set_aw(1, 4'h6, 32'h600, 8'd0); set_w(1, 64'h36, 1'b1);
    @(negedge clk); #1;
    chk("t3_m1_granted", m_awid, 5'h16);
    chk("t3_m1_awready", s_awready, 2'b10);
    @(negedge clk);
    s_awvalid[1] = 1'b0;
    #1;
    chk("t3_m1_wdata", m_wdata, 64'h36);
    @(negedge clk);
    s_wvalid[1] = 1'b0;
    #1;
    chk("t3_m0_still_capped", m_awvalid, 0);
    m_bvalid = 1'b1; m_bid = 5'h01; m_bresp = 2'd0; s_bready = 2'b01;
    #1;
    chk("t3_b_to_m0", s_bvalid, 2'b01);
    @(negedge clk);
    m_bvalid = 1'b0; s_bready = 2'b00;
    @(negedge clk); #1;
    chk("t3_m0_resumed", m_awvalid, 1);
    chk("t3_m0_resumed_id", m_awid, 5'h07);
    @(negedge clk);
    s_awvalid[0] = 1'b0;
    #1;
    chk("t3_m0_wdata", m_wdata, 64'h37);
    @(negedge clk);
    s_wvalid[0] = 1'b0;
    send_b(5'h02, AXI_RESP_OKAY, 2'b01);
    send_b(5'h07, AXI_RESP_OKAY, 2'b01);
    send_b(5'h16, AXI_RESP_OKAY, 2'b10);

    // ---------------- 4: backpressure ----------------
    @(negedge clk);
    set_aw(0, 4'h9, 32'h900, 8'd3); m_awready = 1'b0; m_wready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("t4_awvalid_held", m_awvalid, 1);
      chk("t4_awaddr_stable", m_awaddr, 32'h900);
      chk("t4_awready_blocked", s_awready, 2'b00);
    end
    m_awready = 1'b1;
    #1;
    chk("t4_awready", s_awready, 2'b01);
    @(negedge clk);
    s_awvalid[0] = 1'b0; m_awready = 1'b0;
    beats = 0;
    mw    = 1'b0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      set_w(0, 64'hB0 + 64'(beats), (beats == 3));
      m_wready = mw;
      #1;
      chk("t4_wdata_stable", m_wdata, 64'hB0 + 64'(beats));
      chk("t4_wvalid", m_wvalid, 1);
      chk("t4_s_wready", s_wready, {1'b0, mw});
      if (mw) beats++;
      mw = !mw;
      @(negedge clk);
    end
    chk("t4_beat_count", beats, 4);
    set_w(0, 64'hBF, 1'b0);
    #1;
    chk("t4_closed_on_wlast", m_wvalid, 0);
    s_wvalid[0] = 1'b0; m_wready = 1'b1;
    send_b(5'h09, AXI_RESP_OKAY, 2'b01);

    // ---------------- 5: early W ----------------
    @(negedge clk);
    set_w(1, 64'hC5, 1'b1); m_wready = 1'b1; m_awready = 1'b1;
    #1;
    chk("t5_early_w0", s_wready, 2'b00);
    @(negedge clk); #1;
    chk("t5_early_w1", s_wready, 2'b00);
    @(negedge clk); #1;
    chk("t5_early_w2", s_wready, 2'b00);
    @(negedge clk);
    set_aw(1, 4'hA, 32'hA00, 8'd0);
    #1;
    chk("t5_idle_wready", s_wready, 2'b00);
    chk("t5_idle_wvalid", m_wvalid, 0);
    @(negedge clk); #1;
    chk("t5_addr_wready", s_wready, 2'b00);
    chk("t5_awid", m_awid, 5'h1A);
    @(negedge clk);
    s_awvalid[1] = 1'b0;
    #1;
    chk("t5_data_wready", s_wready, 2'b10);
    chk("t5_wdata", m_wdata, 64'hC5);
    chk("t5_wlast", m_wlast, 1);
    @(negedge clk);
    s_wvalid[1] = 1'b0;
    send_b(5'h1A, AXI_RESP_OKAY, 2'b10);

    // ---------------- 6: reset mid-burst ----------------
    @(negedge clk);
    set_aw(0, 4'hB, 32'hB00, 8'd3); m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk); #1;
    chk("t6_awvalid", m_awvalid, 1);
    @(negedge clk);
    s_awvalid[0] = 1'b0; set_w(0, 64'hD0, 1'b0);
    #1;
    chk("t6_beat1", m_wdata, 64'hD0);
    @(negedge clk);
    set_w(0, 64'hD1, 1'b0);
    #1;
    chk("t6_beat2", m_wdata, 64'hD1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wvalid", m_wvalid, 0);
    chk("t6_rst_wready", s_wready, 2'b00);
    chk("t6_rst_wdata", m_wdata, 0);
    chk("t6_rst_awvalid", m_awvalid, 0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_aw(1, 4'hC, 32'hC00, 8'd1); m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk); #1;
    chk("t6_m1_awid", m_awid, 5'h1C);
    chk("t6_m1_awlen", m_awlen, 8'd1);
    @(negedge clk);
    s_awvalid[1] = 1'b0; set_w(1, 64'hE0, 1'b0);
    #1;
    chk("t6_m1_beat1", m_wdata, 64'hE0);
    chk("t6_m1_wready", s_wready, 2'b10);
    @(negedge clk);
    set_w(1, 64'hE1, 1'b1);
    #1;
    chk("t6_m1_beat2", m_wdata, 64'hE1);
    chk("t6_m1_wlast", m_wlast, 1);
    @(negedge clk);
    s_wvalid[1] = 1'b0;
    #1;
    chk("t6_m1_done", m_wvalid, 0);
    send_b(5'h1C, AXI_RESP_OKAY, 2'b10);
    burst1(0, 4'h1, 32'h110, 64'hF1);
    burst1(0, 4'h2, 32'h120, 64'hF2);
    @(negedge clk);
    set_aw(0, 4'h3, 32'h130, 8'd0); set_w(0, 64'hF3, 1'b1);
    @(negedge clk); #1;
    chk("t6_m0_cap_after_reset", m_awvalid, 0);
    s_awvalid = '0; s_wvalid = '0;
    send_b(5'h01, AXI_RESP_OKAY, 2'b01);
    send_b(5'h02, AXI_RESP_OKAY, 2'b01);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
